// File: rtl/delay_chain_seq.sv
// delay_chain_seq: launches a programmed number of edges into the delay chain and checks that they all come back.
// Optional build macro DCS_LATENCY_EN adds the first-edge latency counter; without it first_lat reads 0.

module delay_chain_seq #(
  parameter int CNT_W = 16,
  parameter int PER_W = 8,
  parameter int TO_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PER_W-1:0] half_period,
  input  logic [CNT_W-1:0] num_toggles,
  input  logic [TO_W-1:0]  drain_timeout,
  output logic             chain_in,
  input  logic             chain_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] edges_seen,
  output logic [TO_W-1:0]  first_lat
);

  // state | meaning
  // IDLE  | waiting for start; chain_in holds its level
  // DRIVE | launching edges, one every half_period cycles
  // DRAIN | waiting for the returning edges or the drain timeout
  // DONE  | one-cycle done pulse; pass/edges_seen final
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [PER_W-1:0] hp_l;
  logic [CNT_W-1:0] num_l;
  logic [TO_W-1:0]  to_l;
  logic [PER_W-1:0] per_cnt;
  logic [CNT_W-1:0] remaining;
  logic [TO_W-1:0]  drain_cnt;
  logic             sync1, sync2, sync3;

  logic [PER_W-1:0] hp_eff;
  logic             counting;
  logic             edge_cnt;
  logic             drain_hit;
  logic             drain_exp;
  logic             first_tog;

  assign hp_eff    = (half_period == '0) ? PER_W'(1) : half_period;
  assign counting  = (state == S_DRIVE) || (state == S_DRAIN);
  assign edge_cnt  = counting && (sync2 ^ sync3);
  assign drain_hit = (edges_seen == num_l);
  assign drain_exp = (drain_cnt == '0);
  assign first_tog = (state == S_DRIVE) && (per_cnt == '0) && (remaining == num_l);

  assign busy = counting;
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hp_l       <= '0;
      num_l      <= '0;
      to_l       <= '0;
      per_cnt    <= '0;
      remaining  <= '0;
      drain_cnt  <= '0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      chain_in   <= 1'b0;
      pass       <= 1'b0;
      edges_seen <= '0;
    end else begin
      sync1 <= chain_out;
      sync2 <= sync1;
      sync3 <= sync2;

      if (edge_cnt && (edges_seen != '1))
        edges_seen <= edges_seen + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (start) begin
            hp_l       <= hp_eff;
            num_l      <= num_toggles;
            to_l       <= drain_timeout;
            edges_seen <= '0;
            // a zero-length run has nothing to miss, so it passes outright
            pass       <= (num_toggles == '0);
            if (num_toggles == '0) begin
              state <= S_DONE;
            end else begin
              per_cnt   <= hp_eff - PER_W'(1);
              remaining <= num_toggles;
              state     <= S_DRIVE;
            end
          end
        end
        S_DRIVE: begin
          if (per_cnt == '0) begin
            chain_in  <= ~chain_in;
            per_cnt   <= hp_l - PER_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              drain_cnt <= to_l;
              state     <= S_DRAIN;
            end
          end else begin
            per_cnt <= per_cnt - PER_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_hit) begin
            pass  <= 1'b1;
            state <= S_DONE;
          end else if (drain_exp) begin
            pass  <= 1'b0;
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - TO_W'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCS_LATENCY_EN
  logic            lat_on;
  logic            first_seen;
  logic [TO_W-1:0] lat_cnt;

  // lat_cnt reads 1 in the cycle the first toggle is visible, so the captured value is cycles-to-detection
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_on     <= 1'b0;
      first_seen <= 1'b0;
      lat_cnt    <= '0;
      first_lat  <= '0;
    end else if ((state == S_IDLE) && start) begin
      lat_on     <= 1'b0;
      first_seen <= 1'b0;
      lat_cnt    <= '0;
      first_lat  <= (num_toggles == '0) ? '1 : '0;
    end else begin
      if (first_tog && !first_seen) begin
        lat_on  <= 1'b1;
        lat_cnt <= TO_W'(1);
      end else if (lat_on && (lat_cnt != '1)) begin
        lat_cnt <= lat_cnt + TO_W'(1);
      end
      if (edge_cnt && !first_seen) begin
        first_seen <= 1'b1;
        lat_on     <= 1'b0;
        first_lat  <= lat_on ? lat_cnt : '0;
      end
      if ((state == S_DRAIN) && (drain_hit || drain_exp) && !first_seen && !edge_cnt)
        first_lat <= '1;
    end
  end
`else
  assign first_lat = '0;
`endif

endmodule

// File: tb/tb_delay_chain_seq.sv
// Self-checking bench for delay_chain_seq: timeline reference model feeding a done-triggered scoreboard.
// Honours DCS_LATENCY_EN for the expected first_lat value.

module tb_delay_chain_seq;
  localparam int CNT_W = 16;
  localparam int PER_W = 8;
  localparam int TO_W  = 24;
  localparam int MAXC  = 256;
  localparam int LAT_ONES = (1 << TO_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PER_W-1:0] half_period;
  logic [CNT_W-1:0] num_toggles;
  logic [TO_W-1:0]  drain_timeout;
  logic             chain_in;
  logic             chain_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] edges_seen;
  logic [TO_W-1:0]  first_lat;

  delay_chain_seq #(.CNT_W(CNT_W), .PER_W(PER_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .half_period(half_period),
    .num_toggles(num_toggles), .drain_timeout(drain_timeout),
    .chain_in(chain_in), .chain_out(chain_out), .busy(busy), .done(done),
    .pass(pass), .edges_seen(edges_seen), .first_lat(first_lat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int done_cyc;
    int pass;
    int edges;
    int lat;
  } exp_t;
  exp_t sb_q[$];

  bit lvl = 1'b0;
  bit cinm[MAXC];
  bit co[MAXC];
  int ev[MAXC];
  int cntv[MAXC];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("pass", pass, e.pass);
          check("edges_seen", edges_seen, e.edges);
          check("first_lat", first_lat, e.lat);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      start     = 1'b0;
      chain_out = lvl;
    end
  endtask

  // Cycle c = cycle after the clock edge that samples start (start is high in cycle 0).
  // gmode: 0 echo of chain_in delayed d cycles, 1 echo plus inverted pulse, 2 chain_out held
  task automatic run_case(input int hp, input int n, input int to, input int d,
                          input int gmode, input int g_at, input int g_len, input bit repulse);
    int hpe, ntog, e_cyc, x, rp, first_t, lat;
    bit p, prev, base;
    exp_t ex;
    hpe = (hp == 0) ? 1 : hp;
    for (int c = 0; c < MAXC; c++) begin
      ntog = (c < 1) ? 0 : (c - 1) / hpe;
      if (ntog > n) ntog = n;
      cinm[c] = lvl ^ ntog[0];
    end
    for (int c = 0; c < MAXC; c++) begin
      if (gmode == 2) base = lvl;
      else base = (c - d < 0) ? lvl : cinm[c - d];
      if (gmode == 1 && c >= g_at && c < g_at + g_len) base = ~base;
      co[c] = base;
    end
    // a chain_out change in cycle c shows up in edges_seen in cycle c+3
    for (int c = 0; c < MAXC; c++) ev[c] = 0;
    prev = lvl;
    for (int c = 0; c + 3 < MAXC; c++) begin
      if (co[c] != prev) ev[c + 3] = 1;
      prev = co[c];
    end
    cntv[0] = ev[0];
    for (int c = 1; c < MAXC; c++) cntv[c] = cntv[c - 1] + ev[c];

    if (n == 0) begin
      x = 0;
      p = 1'b1;
      ex.edges = 0;
      first_t = -1;
    end else begin
      e_cyc = n * hpe + 1;
      x = e_cyc;
      p = 1'b0;
      while (x < MAXC - 8) begin
        if (cntv[x] == n) begin p = 1'b1; break; end
        if (x - e_cyc == to) break;
        x++;
      end
      ex.edges = cntv[x + 1];
      first_t = -1;
      for (int t = 2; t <= x + 1; t++)
        if (ev[t] != 0 && first_t < 0) first_t = t;
    end
    if (first_t < 0) lat = LAT_ONES;
    else lat = (first_t > hpe + 1) ? first_t - (hpe + 1) : 0;
`ifdef DCS_LATENCY_EN
    ex.lat = lat;
`else
    ex.lat = 0;
`endif
    ex.pass = int'(p);
    rp = (repulse && x >= 1) ? int'($urandom_range(x, 1)) : -1;

    for (int c = 0; c <= x + 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ex.done_cyc = cyc + x + 1;
        sb_q.push_back(ex);
      end
      check("chain_in", chain_in, cinm[c]);
      check("busy", busy, (n > 0 && c >= 1 && c <= x) ? 1 : 0);
      start = (c == 0) || (c == rp);
      if (c == 0) begin
        half_period   = PER_W'(hp);
        num_toggles   = CNT_W'(n);
        drain_timeout = TO_W'(to);
      end else begin
        half_period   = PER_W'($urandom);
        num_toggles   = CNT_W'($urandom_range(n + 5, n + 1));
        drain_timeout = TO_W'($urandom);
      end
      chain_out = co[c];
    end
    lvl = lvl ^ n[0];
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int hp, n, to, d, gm;
    rst = 1'b1; start = 1'b0; chain_out = 1'b0;
    half_period = '0; num_toggles = '0; drain_timeout = '0;
    repeat (3) @(negedge clk);
    check("rst_chain_in", chain_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_edges_seen", edges_seen, 0);
    check("rst_first_lat", first_lat, 0);
    rst = 1'b0;
    idle(4);

    run_case(2, 4, 50, 5, 0, 0, 0, 1'b0);     // echo delayed 5: pass, 4 edges
    idle(4);
    run_case(4, 3, 20, 0, 2, 0, 0, 1'b0);     // chain_out held: timeout
    idle(4);
    run_case(3, 0, 10, 0, 0, 0, 0, 1'b0);     // zero toggles
    idle(4);
    run_case(10, 2, 2, 4, 1, 5, 2, 1'b0);     // glitch in DRIVE: 3 edges, fail
    idle(4);

    // reset in DRIVE after 2 of 10 toggles
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      start = (c == 0);
      half_period = PER_W'(3);
      num_toggles = CNT_W'(10);
      drain_timeout = TO_W'(40);
      chain_out = lvl;
    end
    check("pre_rst_busy", busy, 1);
    check("pre_rst_chain_in", chain_in, lvl);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_chain_in", chain_in, 0);
    check("abort_done", done, 0);
    check("abort_edges_seen", edges_seen, 0);
    rst = 1'b0;
    lvl = 1'b0;
    chain_out = 1'b0;
    @(negedge clk);
    check("abort_no_done", done, 0);
    idle(4);
    run_case(1, 3, 15, 2, 0, 0, 0, 1'b0);     // start accepted after abort
    idle(4);
    run_case(2, 5, 30, 3, 0, 0, 0, 1'b1);     // start re-pulsed mid-run
    idle(4);

    for (int i = 0; i < 40; i++) begin
      hp = $urandom_range(5, 0);
      n  = $urandom_range(8, 1);
      to = $urandom_range(30, 0);
      d  = $urandom_range(12, 0);
      gm = $urandom_range(5, 0);
      if (gm > 2) gm = 0;
      run_case(hp, n, to, d, gm, $urandom_range(60, 0), $urandom_range(3, 1), $urandom_range(1, 0) == 1);
      idle(4);
    end

    idle(4);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
